// File: rtl/dcache_port_arbiter.sv
// ============================================================================
// Module   : dcache_port_arbiter
// Brief    : Round-robin arbiter sharing the dcache request port between the
//            EX load/store path (r0) and the cache-maintenance path (r1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              r0_valid,
    input  logic              r0_op,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic [STRB_W-1:0] r0_wstrb,
    output logic              r0_addr_ok,
    input  logic              r1_valid,
    input  logic              r1_is_cacop,
    input  logic              r1_is_preld,
    input  logic [4:0]        r1_cacop_code,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r1_addr_ok,
    output logic              dc_valid,
    output logic              dc_op,
    output logic [ADDR_W-1:0] dc_addr,
    output logic [DATA_W-1:0] dc_wdata,
    output logic [STRB_W-1:0] dc_wstrb,
    output logic              dc_is_cacop,
    output logic              dc_is_preld,
    output logic [4:0]        dc_cacop_code,
    input  logic              dc_addr_ok,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD0 = 2'd1,
        S_HOLD1 = 2'd2
    } state_t;

    localparam logic [STRB_W-1:0] c_FULL_STRB = {STRB_W{1'b1}};

    state_t            r_state, w_state_nxt;
    logic              r_rr_ptr, w_rr_nxt;
    logic              r_kill, w_kill_nxt;
    logic              w_capture;

    logic              r_h_op;
    logic [ADDR_W-1:0] r_h_addr;
    logic [DATA_W-1:0] r_h_wdata;
    logic [STRB_W-1:0] r_h_wstrb;
    logic              r_h_is_cacop;
    logic              r_h_is_preld;
    logic [4:0]        r_h_code;

    logic              w_grant0, w_grant1;
    logic              w_req_op;
    logic [ADDR_W-1:0] w_req_addr;
    logic [DATA_W-1:0] w_req_wdata;
    logic [STRB_W-1:0] w_req_wstrb;
    logic              w_req_is_cacop;
    logic              w_req_is_preld;
    logic [4:0]        w_req_code;

    // Grants are suppressed while reset is asserted so an async reset mid-hold
    // drops dc_valid immediately even with requesters still valid.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!rst && !flush) begin
            w_grant0 = r0_valid && (!r1_valid || !r_rr_ptr);
            w_grant1 = r1_valid && (!r0_valid ||  r_rr_ptr);
        end
    end

    always_comb begin
        w_req_op       = r0_op;
        w_req_addr     = r0_addr;
        w_req_wdata    = r0_wdata;
        w_req_wstrb    = r0_wstrb;
        w_req_is_cacop = 1'b0;
        w_req_is_preld = 1'b0;
        w_req_code     = 5'd0;
        if (w_grant1) begin
            w_req_op       = 1'b0;
            w_req_addr     = r1_addr;
            w_req_wdata    = '0;
            w_req_wstrb    = c_FULL_STRB;
            w_req_is_cacop = r1_is_cacop;
            w_req_is_preld = r1_is_preld;
            w_req_code     = r1_cacop_code;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rr_nxt      = r_rr_ptr;
        w_kill_nxt    = r_kill;
        w_capture     = 1'b0;
        dc_valid      = 1'b0;
        dc_op         = 1'b0;
        dc_addr       = '0;
        dc_wdata      = '0;
        dc_wstrb      = c_FULL_STRB;
        dc_is_cacop   = 1'b0;
        dc_is_preld   = 1'b0;
        dc_cacop_code = 5'd0;
        r0_addr_ok    = 1'b0;
        r1_addr_ok    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant0 || w_grant1) begin
                    dc_valid      = 1'b1;
                    dc_op         = w_req_op;
                    dc_addr       = w_req_addr;
                    dc_wdata      = w_req_wdata;
                    dc_wstrb      = w_req_wstrb;
                    dc_is_cacop   = w_req_is_cacop;
                    dc_is_preld   = w_req_is_preld;
                    dc_cacop_code = w_req_code;
                    if (dc_addr_ok) begin
                        r0_addr_ok = w_grant0;
                        r1_addr_ok = w_grant1;
                        w_rr_nxt   = w_grant0;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = w_grant1 ? S_HOLD1 : S_HOLD0;
                    end
                end
            end
            S_HOLD0, S_HOLD1: begin
                dc_valid      = 1'b1;
                dc_op         = r_h_op;
                dc_addr       = r_h_addr;
                dc_wdata      = r_h_wdata;
                dc_wstrb      = r_h_wstrb;
                dc_is_cacop   = r_h_is_cacop;
                dc_is_preld   = r_h_is_preld;
                dc_cacop_code = r_h_code;
                if (dc_addr_ok) begin
                    // A flush in the accept cycle kills the ack just like an earlier one.
                    r0_addr_ok  = (r_state == S_HOLD0) && !r_kill && !flush;
                    r1_addr_ok  = (r_state == S_HOLD1) && !r_kill && !flush;
                    w_rr_nxt    = (r_state == S_HOLD0);
                    w_kill_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (flush) begin
                    w_kill_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= 1'b0;
            r_kill       <= 1'b0;
            r_h_op       <= 1'b0;
            r_h_addr     <= '0;
            r_h_wdata    <= '0;
            r_h_wstrb    <= '0;
            r_h_is_cacop <= 1'b0;
            r_h_is_preld <= 1'b0;
            r_h_code     <= 5'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_kill   <= w_kill_nxt;
            if (w_capture) begin
                r_h_op       <= w_req_op;
                r_h_addr     <= w_req_addr;
                r_h_wdata    <= w_req_wdata;
                r_h_wstrb    <= w_req_wstrb;
                r_h_is_cacop <= w_req_is_cacop;
                r_h_is_preld <= w_req_is_preld;
                r_h_code     <= w_req_code;
            end
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dcache_port_arbiter.sv
// ============================================================================
// Module   : tb_dcache_port_arbiter
// Brief    : Directed self-checking bench for dcache_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        r0_valid, r0_op;
    logic [31:0] r0_addr, r0_wdata;
    logic [3:0]  r0_wstrb;
    logic        r0_addr_ok;
    logic        r1_valid, r1_is_cacop, r1_is_preld;
    logic [4:0]  r1_cacop_code;
    logic [31:0] r1_addr;
    logic        r1_addr_ok;
    logic        dc_valid, dc_op;
    logic [31:0] dc_addr, dc_wdata;
    logic [3:0]  dc_wstrb;
    logic        dc_is_cacop, dc_is_preld;
    logic [4:0]  dc_cacop_code;
    logic        dc_addr_ok;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dcache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STRB_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .r0_valid(r0_valid), .r0_op(r0_op), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_wstrb(r0_wstrb), .r0_addr_ok(r0_addr_ok),
        .r1_valid(r1_valid), .r1_is_cacop(r1_is_cacop), .r1_is_preld(r1_is_preld),
        .r1_cacop_code(r1_cacop_code), .r1_addr(r1_addr), .r1_addr_ok(r1_addr_ok),
        .dc_valid(dc_valid), .dc_op(dc_op), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_wstrb(dc_wstrb), .dc_is_cacop(dc_is_cacop), .dc_is_preld(dc_is_preld),
        .dc_cacop_code(dc_cacop_code), .dc_addr_ok(dc_addr_ok), .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are checked 1-2ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_oks(input string tag, input logic e0, input logic e1);
        check_eq({tag, ".r0_ok"}, {63'd0, r0_addr_ok}, {63'd0, e0});
        check_eq({tag, ".r1_ok"}, {63'd0, r1_addr_ok}, {63'd0, e1});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        r0_valid = 1'b0; r0_op = 1'b0; r0_addr = '0; r0_wdata = '0; r0_wstrb = 4'hF;
        r1_valid = 1'b0; r1_is_cacop = 1'b0; r1_is_preld = 1'b0; r1_cacop_code = '0; r1_addr = '0;
        dc_addr_ok = 1'b0;

        // Reset state
        tick();
        check_eq("rst.dc_valid", {63'd0, dc_valid}, 64'd0);
        check_eq("rst.dc_wstrb", {60'd0, dc_wstrb}, 64'hF);
        check_eq("rst.dc_addr", {32'd0, dc_addr}, 64'd0);
        check_eq("rst.busy", {63'd0, busy}, 64'd0);
        check_oks("rst", 1'b0, 1'b0);
        rst = 1'b0;

        // Zero-wait read from r0
        tick();
        r0_valid = 1'b1; r0_op = 1'b0; r0_addr = 32'h1C00_0100; dc_addr_ok = 1'b1;
        settle();
        check_eq("zw.dc_valid", {63'd0, dc_valid}, 64'd1);
        check_eq("zw.dc_addr", {32'd0, dc_addr}, 64'h1C00_0100);
        check_eq("zw.dc_op", {63'd0, dc_op}, 64'd0);
        check_oks("zw", 1'b1, 1'b0);
        check_eq("zw.busy", {63'd0, busy}, 64'd0);
        tick();
        r0_valid = 1'b0; dc_addr_ok = 1'b0;
        settle();
        check_eq("zw.busy_after", {63'd0, busy}, 64'd0);

        // Held write; r0 fields turn to garbage after the first cycle
        tick();
        r0_valid = 1'b1; r0_op = 1'b1; r0_addr = 32'h8000_0004;
        r0_wdata = 32'hDEAD_BEEF; r0_wstrb = 4'b0011; dc_addr_ok = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) begin
                r0_op = 1'b0; r0_addr = 32'h1234_5678; r0_wdata = 32'h0; r0_wstrb = 4'b1100;
            end
            if (c == 4) dc_addr_ok = 1'b1;
            settle();
            check_eq($sformatf("hw%0d.dc_valid", c), {63'd0, dc_valid}, 64'd1);
            check_eq($sformatf("hw%0d.dc_addr", c), {32'd0, dc_addr}, 64'h8000_0004);
            check_eq($sformatf("hw%0d.dc_wdata", c), {32'd0, dc_wdata}, 64'hDEAD_BEEF);
            check_eq($sformatf("hw%0d.dc_wstrb", c), {60'd0, dc_wstrb}, 64'h3);
            check_eq($sformatf("hw%0d.dc_op", c), {63'd0, dc_op}, 64'd1);
            check_eq($sformatf("hw%0d.busy", c), {63'd0, busy}, (c >= 2) ? 64'd1 : 64'd0);
            check_oks($sformatf("hw%0d", c), (c == 4), 1'b0);
            tick();
        end
        r0_valid = 1'b0; dc_addr_ok = 1'b0;
        settle();
        check_eq("hw.idle_busy", {63'd0, busy}, 64'd0);

        // Round robin: pointer now favours r1, so grants go r1, r0, r1, r0
        tick();
        r0_valid = 1'b1; r0_op = 1'b1; r0_addr = 32'h1C00_0200; r0_wdata = 32'h1122_3344; r0_wstrb = 4'hF;
        r1_valid = 1'b1; r1_is_cacop = 1'b1; r1_is_preld = 1'b0; r1_cacop_code = 5'b01001;
        r1_addr = 32'hA000_0040; dc_addr_ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            logic g1;
            g1 = (c % 2 == 0);
            settle();
            check_oks($sformatf("rr%0d", c), !g1, g1);
            check_eq($sformatf("rr%0d.dc_addr", c), {32'd0, dc_addr}, g1 ? 64'hA000_0040 : 64'h1C00_0200);
            check_eq($sformatf("rr%0d.cacop", c), {63'd0, dc_is_cacop}, {63'd0, g1});
            check_eq($sformatf("rr%0d.code", c), {59'd0, dc_cacop_code}, g1 ? 64'h9 : 64'h0);
            check_eq($sformatf("rr%0d.dc_op", c), {63'd0, dc_op}, g1 ? 64'd0 : 64'd1);
            check_eq($sformatf("rr%0d.dc_wdata", c), {32'd0, dc_wdata}, g1 ? 64'd0 : 64'h1122_3344);
            check_eq($sformatf("rr%0d.busy", c), {63'd0, busy}, 64'd0);
            tick();
        end
        r0_valid = 1'b0; r1_valid = 1'b0; r1_is_cacop = 1'b0; r1_cacop_code = '0; dc_addr_ok = 1'b0;

        // Flush during HOLD1 with a PRELD; accept arrives two cycles after the flush
        tick();
        r1_valid = 1'b1; r1_is_preld = 1'b1; r1_addr = 32'hB000_0080;
        settle();
        check_eq("fh1.dc_valid", {63'd0, dc_valid}, 64'd1);
        check_eq("fh1.preld", {63'd0, dc_is_preld}, 64'd1);
        check_oks("fh1", 1'b0, 1'b0);
        tick();
        r1_valid = 1'b0; r1_is_preld = 1'b0; r1_addr = 32'h0; flush = 1'b1;
        settle();
        check_eq("fh2.dc_valid", {63'd0, dc_valid}, 64'd1);
        check_eq("fh2.dc_addr", {32'd0, dc_addr}, 64'hB000_0080);
        check_eq("fh2.preld", {63'd0, dc_is_preld}, 64'd1);
        check_eq("fh2.busy", {63'd0, busy}, 64'd1);
        tick();
        flush = 1'b0;
        settle();
        check_eq("fh3.dc_valid", {63'd0, dc_valid}, 64'd1);
        check_oks("fh3", 1'b0, 1'b0);
        tick();
        dc_addr_ok = 1'b1;
        settle();
        check_eq("fh4.dc_valid", {63'd0, dc_valid}, 64'd1);
        check_oks("fh4", 1'b0, 1'b0);
        tick();
        dc_addr_ok = 1'b0;
        settle();
        check_eq("fh5.busy", {63'd0, busy}, 64'd0);
        check_eq("fh5.dc_valid", {63'd0, dc_valid}, 64'd0);

        // Flush coinciding with accept in HOLD0 suppresses the ack
        tick();
        r0_valid = 1'b1; r0_op = 1'b0; r0_addr = 32'h1C00_0300;
        tick();
        flush = 1'b1; dc_addr_ok = 1'b1;
        settle();
        check_eq("fa.dc_addr", {32'd0, dc_addr}, 64'h1C00_0300);
        check_oks("fa", 1'b0, 1'b0);
        tick();
        r0_valid = 1'b0; dc_addr_ok = 1'b0; flush = 1'b0;
        settle();
        check_eq("fa.busy", {63'd0, busy}, 64'd0);

        // Flush in IDLE blocks the grant until it drops
        tick();
        flush = 1'b1; r0_valid = 1'b1; r0_addr = 32'h1C00_0400; dc_addr_ok = 1'b1;
        settle();
        check_eq("fi.dc_valid", {63'd0, dc_valid}, 64'd0);
        check_oks("fi", 1'b0, 1'b0);
        tick();
        flush = 1'b0;
        settle();
        check_eq("fi2.dc_valid", {63'd0, dc_valid}, 64'd1);
        check_eq("fi2.dc_addr", {32'd0, dc_addr}, 64'h1C00_0400);
        check_oks("fi2", 1'b1, 1'b0);
        tick();

        // Async reset mid-HOLD0 (pointer favours r1 beforehand)
        r0_addr = 32'h1C00_0500; dc_addr_ok = 1'b0;
        tick();
        settle();
        check_eq("ar.busy_pre", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        settle();
        check_eq("ar.dc_valid", {63'd0, dc_valid}, 64'd0);
        check_eq("ar.busy", {63'd0, busy}, 64'd0);
        tick();
        rst = 1'b0;
        r1_valid = 1'b1; r1_addr = 32'hA000_0100; dc_addr_ok = 1'b1;
        settle();
        check_oks("ar.first", 1'b1, 1'b0);
        check_eq("ar.first_addr", {32'd0, dc_addr}, 64'h1C00_0500);
        tick();
        check_oks("ar.second", 1'b0, 1'b1);
        r0_valid = 1'b0; r1_valid = 1'b0; dc_addr_ok = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
